stopwatch_display_mux: RTL and testbench

- Downstream consumer of the seconds and minutes mod-60 counters in the stopwatch datapath.
- Takes the two 6-bit binary counts, converts each to two decimal digits, and time-multiplexes them onto a 4-digit common-anode seven-segment display.
- Supports blinking of the selected field (minutes or seconds) while the stopwatch is in adjust mode.

---
 rtl/stopwatch_display_mux_pkg.sv | 30 +++
 rtl/stopwatch_display_mux_seg7_decode.sv | 38 +++
 rtl/stopwatch_display_mux.sv | 141 ++++++++++++++
 tb/tb_stopwatch_display_mux.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_display_mux_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_display_mux_pkg
// Shared constants for the stopwatch seven-segment display multiplexer:
//   - active-low segment patterns {g,f,e,d,c,b,a} for digits 0-9, dash, blank
//   - scan-index values for each of the four display positions
//   - largest legal counter value (anything above shows as dashes)
// -----------------------------------------------------------------------------
package stopwatch_display_mux_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] IDX_SEC_ONES = 2'd0;
    localparam logic [1:0] IDX_SEC_TENS = 2'd1;
    localparam logic [1:0] IDX_MIN_ONES = 2'd2;
    localparam logic [1:0] IDX_MIN_TENS = 2'd3;

    localparam int SW_MAX_VAL = 59;

endpackage

// File: rtl/stopwatch_display_mux_seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD digit to active-low seven-segment pattern.
// Ports:
//   i_bcd   [3:0]  BCD digit 0-9 (10-15 decode to blank)
//   i_dash         1 = show a dash regardless of i_bcd
//   o_seg   [6:0]  segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seg7_decode
    import stopwatch_display_mux_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_dash,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (i_dash) begin
            o_seg = SEG_DASH;
        end else begin
            case (i_bcd)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/stopwatch_display_mux.sv
// -----------------------------------------------------------------------------
// stopwatch_display_mux
// Converts the binary seconds/minutes counts to decimal digits and scans them
// onto a 4-digit common-anode seven-segment display (MM.SS, with the decimal
// point of the minutes-ones digit standing in for a colon). In adjust mode the
// selected field blinks.
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-low
//   scan_tick    one-cycle pulse, advances the digit scan
//   blink_tick   one-cycle pulse, toggles the blink phase
//   adj          1 = adjust mode (blinking enabled)
//   sel          field that blinks: 0 = seconds, 1 = minutes
//   sec_val[5:0] seconds count, binary
//   min_val[5:0] minutes count, binary
//   an[3:0]      digit anodes, active-low
//   seg[6:0]     segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low
// -----------------------------------------------------------------------------
module stopwatch_display_mux
    import stopwatch_display_mux_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int MAX_VAL    = SW_MAX_VAL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_tick,
    input  logic                  blink_tick,
    input  logic                  adj,
    input  logic                  sel,
    input  logic [5:0]            sec_val,
    input  logic [5:0]            min_val,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam logic [5:0]            MAX6   = 6'(MAX_VAL);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

    // Compare/subtract chain; valid for v <= 59, tens never exceeds 5.
    function automatic logic [7:0] bin2bcd(input logic [5:0] v);
        logic [5:0] r;
        logic [3:0] t;
        r = v;
        t = 4'd0;
        if (r >= 6'd50) begin
            t = 4'd5; r = r - 6'd50;
        end else if (r >= 6'd40) begin
            t = 4'd4; r = r - 6'd40;
        end else if (r >= 6'd30) begin
            t = 4'd3; r = r - 6'd30;
        end else if (r >= 6'd20) begin
            t = 4'd2; r = r - 6'd20;
        end else if (r >= 6'd10) begin
            t = 4'd1; r = r - 6'd10;
        end
        return {t, 4'(r)};
    endfunction

    logic [1:0]            r_idx;
    logic                  r_phase;
    logic [5:0]            r_sec_snap;
    logic [5:0]            r_min_snap;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;
    logic                  r_dp;

    logic [1:0]            w_idx_nxt;
    logic                  w_phase_nxt;
    logic                  w_wrap;
    logic                  w_is_min;
    logic [7:0]            w_sec_bcd;
    logic [7:0]            w_min_bcd;
    logic [7:0]            w_field_bcd;
    logic [3:0]            w_digit;
    logic                  w_dash;
    logic                  w_blank;
    logic [6:0]            w_seg;
    logic [NUM_DIGITS-1:0] w_an_on;

    assign w_idx_nxt   = scan_tick ? (r_idx + 2'd1) : r_idx;
    assign w_phase_nxt = r_phase ^ blink_tick;
    assign w_wrap      = scan_tick && (r_idx == IDX_MIN_TENS);

    // Index bit 1 selects the minutes field, bit 0 the tens digit.
    assign w_is_min    = w_idx_nxt[1];
    assign w_sec_bcd   = bin2bcd(r_sec_snap);
    assign w_min_bcd   = bin2bcd(r_min_snap);
    assign w_field_bcd = w_is_min ? w_min_bcd : w_sec_bcd;
    assign w_digit     = w_idx_nxt[0] ? w_field_bcd[7:4] : w_field_bcd[3:0];
    assign w_dash      = w_is_min ? (r_min_snap > MAX6) : (r_sec_snap > MAX6);
    assign w_blank     = adj && w_phase_nxt && (sel == w_is_min);
    assign w_an_on     = ~(NUM_DIGITS'(1) << w_idx_nxt);

    seg7_decode u_seg7_decode (
        .i_bcd  (w_digit),
        .i_dash (w_dash),
        .o_seg  (w_seg)
    );

    // The output register is loaded from the upcoming index and blink phase,
    // but from the snapshot as it stands before this edge. On the wrap edge
    // the index-0 digit therefore still belongs to the frame being finished,
    // so every frame (indices 1,2,3,0) comes from a single snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx      <= IDX_SEC_ONES;
            r_phase    <= 1'b0;
            r_sec_snap <= 6'd0;
            r_min_snap <= 6'd0;
            r_an       <= AN_OFF;
            r_seg      <= SEG_BLANK;
            r_dp       <= 1'b1;
        end else begin
            r_idx   <= w_idx_nxt;
            r_phase <= w_phase_nxt;
            if (w_wrap) begin
                r_sec_snap <= sec_val;
                r_min_snap <= min_val;
            end
            if (scan_tick) begin
                if (w_blank) begin
                    r_an  <= AN_OFF;
                    r_seg <= SEG_BLANK;
                    r_dp  <= 1'b1;
                end else begin
                    r_an  <= w_an_on;
                    r_seg <= w_seg;
                    r_dp  <= (w_idx_nxt != IDX_MIN_ONES);
                end
            end
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: tb/tb_stopwatch_display_mux.sv
module tb_stopwatch_display_mux;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scan_tick = 1'b0;
    logic       blink_tick = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [5:0] sec_val = 6'd0;
    logic [5:0] min_val = 6'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    always #5 clk = ~clk;

    stopwatch_display_mux dut (
        .clk        (clk),
        .rst        (rst),
        .scan_tick  (scan_tick),
        .blink_tick (blink_tick),
        .adj        (adj),
        .sel        (sel),
        .sec_val    (sec_val),
        .min_val    (min_val),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    typedef struct {
        logic [5:0] sec;
        logic [5:0] min;
        logic [6:0] s0;
        logic [6:0] s1;
        logic [6:0] s2;
        logic [6:0] s3;
    } vec_t;

    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic [6:0] tseg [10];
    vec_t       vecs [7];
    exp_t       exp_q [$];
    int         n_vec = 0;
    int         n_err = 0;

    // reference state of the display
    logic [1:0] m_idx;
    logic       m_ph;
    logic [5:0] m_sec;
    logic [5:0] m_min;
    exp_t       m_last;

    function automatic exp_t mk(input logic [3:0] a, input logic [6:0] s, input logic d);
        exp_t e;
        e.an = a; e.seg = s; e.dp = d;
        return e;
    endfunction

    function automatic exp_t model_out(input logic [1:0] idx, input logic ph);
        exp_t e;
        int   v;
        v = idx[1] ? int'(m_min) : int'(m_sec);
        if (adj && ph && (sel == idx[1])) begin
            e = mk(4'b1111, BLANK, 1'b1);
        end else begin
            e.an      = 4'b1111;
            e.an[idx] = 1'b0;
            e.dp      = (idx == 2'd2) ? 1'b0 : 1'b1;
            if (v > 59)      e.seg = DASH;
            else if (idx[0]) e.seg = tseg[v / 10];
            else             e.seg = tseg[v % 10];
        end
        return e;
    endfunction

    task automatic check(input string name, input exp_t e);
        n_vec++;
        if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
            n_err++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                     name, an, seg, dp, e.an, e.seg, e.dp);
        end
    endtask

    task automatic model_reset();
        m_idx = 2'd0; m_ph = 1'b0; m_sec = 6'd0; m_min = 6'd0;
        m_last = mk(4'b1111, BLANK, 1'b1);
    endtask

    // One clock with the given tick pulses; the expectation is queued when the
    // stimulus is driven and compared after the edge.
    task automatic do_tick(input string name, input logic s, input logic b,
                           input logic lit, input exp_t le);
        exp_t       e;
        exp_t       got;
        logic [1:0] nidx;
        logic       nph;
        @(negedge clk);
        nidx = s ? (m_idx + 2'd1) : m_idx;
        nph  = m_ph ^ b;
        e    = s ? model_out(nidx, nph) : m_last;
        if (lit) e = le;
        exp_q.push_back(e);
        scan_tick  = s;
        blink_tick = b;
        if (s && m_idx == 2'd3) begin
            m_sec = sec_val;
            m_min = min_val;
        end
        m_idx  = nidx;
        m_ph   = nph;
        m_last = e;
        @(posedge clk);
        #1;
        scan_tick  = 1'b0;
        blink_tick = 1'b0;
        got = exp_q.pop_front();
        check(name, got);
    endtask

    task automatic tl(input string name, input logic s, input logic b,
                      input logic [3:0] a, input logic [6:0] sg, input logic d);
        do_tick(name, s, b, 1'b1, mk(a, sg, d));
    endtask

    task automatic tm(input string name, input logic s, input logic b);
        do_tick(name, s, b, 1'b0, mk(4'b1111, BLANK, 1'b1));
    endtask

    // Scan through indices 1,2,3,0 with literal segment expectations.
    task automatic frame(input string name, input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        tl(name, 1'b1, 1'b0, 4'b1101, s1, 1'b1);
        tl(name, 1'b1, 1'b0, 4'b1011, s2, 1'b0);
        tl(name, 1'b1, 1'b0, 4'b0111, s3, 1'b1);
        tl(name, 1'b1, 1'b0, 4'b1110, s0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tseg = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        vecs[0] = '{sec: 6'd34, min: 6'd12, s0: tseg[4], s1: tseg[3], s2: tseg[2], s3: tseg[1]};
        vecs[1] = '{sec: 6'd59, min: 6'd0,  s0: tseg[9], s1: tseg[5], s2: tseg[0], s3: tseg[0]};
        vecs[2] = '{sec: 6'd60, min: 6'd12, s0: DASH,    s1: DASH,    s2: tseg[2], s3: tseg[1]};
        vecs[3] = '{sec: 6'd63, min: 6'd7,  s0: DASH,    s1: DASH,    s2: tseg[7], s3: tseg[0]};
        vecs[4] = '{sec: 6'd0,  min: 6'd59, s0: tseg[0], s1: tseg[0], s2: tseg[9], s3: tseg[5]};
        vecs[5] = '{sec: 6'd45, min: 6'd63, s0: tseg[5], s1: tseg[4], s2: DASH,    s3: DASH};
        vecs[6] = '{sec: 6'd18, min: 6'd36, s0: tseg[8], s1: tseg[1], s2: tseg[6], s3: tseg[3]};

        // Reset held with random activity on the inputs
        #2 rst = 1'b0;
        #1 check("reset_async", mk(4'b1111, BLANK, 1'b1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            scan_tick  = 1'b1;
            blink_tick = 1'($urandom_range(0, 1));
            adj        = 1'($urandom_range(0, 1));
            sel        = 1'($urandom_range(0, 1));
            sec_val    = 6'($urandom_range(0, 63));
            min_val    = 6'($urandom_range(0, 63));
            @(posedge clk);
            #1 check("reset_held", mk(4'b1111, BLANK, 1'b1));
        end
        @(negedge clk);
        scan_tick = 1'b0; blink_tick = 1'b0; adj = 1'b0; sel = 1'b0;
        rst = 1'b1;
        model_reset();

        // First frame still shows the reset snapshot
        sec_val = 6'd34; min_val = 6'd12;
        frame("first_frame_00", tseg[0], tseg[0], tseg[0], tseg[0]);
        frame("second_frame",   tseg[4], tseg[3], tseg[2], tseg[1]);

        // Table of values, each loaded by a flush frame
        for (int i = 0; i < 7; i++) begin
            sec_val = vecs[i].sec;
            min_val = vecs[i].min;
            for (int k = 0; k < 4; k++) tm("flush", 1'b1, 1'b0);
            frame($sformatf("vec%0d", i), vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3);
        end

        // Snapshot coherence: input changes mid-frame
        sec_val = 6'd34; min_val = 6'd12;
        for (int k = 0; k < 4; k++) tm("flush", 1'b1, 1'b0);
        tl("coh_idx1", 1'b1, 1'b0, 4'b1101, tseg[3], 1'b1);
        sec_val = 6'd35;
        tl("coh_idx2", 1'b1, 1'b0, 4'b1011, tseg[2], 1'b0);
        tl("coh_idx3", 1'b1, 1'b0, 4'b0111, tseg[1], 1'b1);
        tl("coh_idx0", 1'b1, 1'b0, 4'b1110, tseg[4], 1'b1);
        frame("coh_next", tseg[5], tseg[3], tseg[2], tseg[1]);

        // Blink minutes in adjust mode
        adj = 1'b1; sel = 1'b1;
        tl("blink_on_hold", 1'b0, 1'b1, 4'b1110, tseg[5], 1'b1);
        tl("blink_sec_tens", 1'b1, 1'b0, 4'b1101, tseg[3], 1'b1);
        tl("blink_min_ones", 1'b1, 1'b0, 4'b1111, BLANK,   1'b1);
        tl("blink_min_tens", 1'b1, 1'b0, 4'b1111, BLANK,   1'b1);
        tl("blink_sec_ones", 1'b1, 1'b0, 4'b1110, tseg[5], 1'b1);
        tl("blink_off_hold", 1'b0, 1'b1, 4'b1110, tseg[5], 1'b1);
        frame("blink_restored", tseg[5], tseg[3], tseg[2], tseg[1]);
        adj = 1'b0;
        tl("noadj_hold", 1'b0, 1'b1, 4'b1110, tseg[5], 1'b1);
        frame("noadj_phase1", tseg[5], tseg[3], tseg[2], tseg[1]);
        tl("noadj_hold2", 1'b0, 1'b1, 4'b1110, tseg[5], 1'b1);

        // Simultaneous scan and blink ticks on the wrap edge
        adj = 1'b1; sel = 1'b0;
        tl("sim_idx1", 1'b1, 1'b0, 4'b1101, tseg[3], 1'b1);
        tl("sim_idx2", 1'b1, 1'b0, 4'b1011, tseg[2], 1'b0);
        tl("sim_idx3", 1'b1, 1'b0, 4'b0111, tseg[1], 1'b1);
        sec_val = 6'd47;
        tl("sim_wrap_blank", 1'b1, 1'b1, 4'b1111, BLANK, 1'b1);
        tl("sim_idx1_blank", 1'b1, 1'b0, 4'b1111, BLANK, 1'b1);
        tl("sim_phase_hold", 1'b0, 1'b1, 4'b1111, BLANK, 1'b1);
        tl("sim_min_ones",   1'b1, 1'b0, 4'b1011, tseg[2], 1'b0);
        tl("sim_min_tens",   1'b1, 1'b0, 4'b0111, tseg[1], 1'b1);
        tl("sim_snap_ones",  1'b1, 1'b0, 4'b1110, tseg[7], 1'b1);
        tl("sim_snap_tens",  1'b1, 1'b0, 4'b1101, tseg[4], 1'b1);
        adj = 1'b0;

        // Reset asserted mid-frame at index 2
        tl("pre_rst_idx2", 1'b1, 1'b0, 4'b1011, tseg[2], 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("rst_mid_async", mk(4'b1111, BLANK, 1'b1));
        @(posedge clk);
        #1 check("rst_mid_held", mk(4'b1111, BLANK, 1'b1));
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        frame("after_rst_00", tseg[0], tseg[0], tseg[0], tseg[0]);
        for (int k = 0; k < 4; k++) tm("after_rst_model", 1'b1, 1'b0);

        // Random traffic against the reference model
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 5) == 0) sec_val = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 5) == 0) min_val = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) adj = ~adj;
            if ($urandom_range(0, 9) == 0) sel = ~sel;
            tm("random", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
